data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 26 ++
 rtl/data_mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle for the data memory controller.
// master issues loads/stores, slave is the controller.
interface data_mem_ctrl_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 9
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_we;
   logic [2:0]               funct3;
   logic [ADDRESS_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0]    rs2;
   logic                     rsp_valid;
   logic [DATA_WIDTH-1:0]    rsp_data;
   logic                     rsp_err;

   modport master (
      output req_valid, req_we, funct3, A, rs2,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_we, funct3, A, rs2,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data memory controller: 3-cycle read-modify-write
// word array with byte/half/word loads and stores.
module data_mem_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int BYTE_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 9
) (
   input  logic           clk,
   input  logic           rst_n,
   data_mem_ctrl_if.slave bus
);
   localparam int DW    = DATA_WIDTH;
   localparam int BW    = BYTE_WIDTH;
   localparam int HW    = 2 * BYTE_WIDTH;
   localparam int AW    = ADDRESS_WIDTH;
   localparam int DEPTH = 2 ** (AW - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            we_q;
   logic [2:0]      f3_q;
   logic [AW-1:0]   a_q;
   logic [DW-1:0]   rs2_q;
   logic [DW-1:0]   RDq;
   logic [DW-1:0]   mem [DEPTH];
   logic            accept;
   logic            err;
   logic [BW-1:0]   bsel;
   logic [HW-1:0]   hsel;
   logic [DW-1:0]   ld_data;
   logic [DW-1:0]   wr_data;

   assign accept = bus.req_valid && bus.req_ready;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state: accept in IDLE, then fixed READ -> EXEC -> IDLE
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = READ;
         READ:    state_nxt = EXEC;
         EXEC:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // capture the request on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q  <= 1'b0;
         f3_q  <= 3'd0;
         a_q   <= '0;
         rs2_q <= '0;
      end else if (accept) begin
         we_q  <= bus.req_we;
         f3_q  <= bus.funct3;
         a_q   <= bus.A;
         rs2_q <= bus.rs2;
      end
   end

   // fetch the addressed word during READ
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              RDq <= '0;
      else if (state == READ)  RDq <= mem[a_q[AW-1:2]];
   end

   // byte and halfword lane selection from the fetched word
   always_comb begin
      bsel = RDq[BW-1:0];
      unique case (a_q[1:0])
         2'd0: bsel = RDq[BW-1:0];
         2'd1: bsel = RDq[2*BW-1:BW];
         2'd2: bsel = RDq[3*BW-1:2*BW];
         2'd3: bsel = RDq[4*BW-1:3*BW];
      endcase
      hsel = a_q[1] ? RDq[4*BW-1:2*BW] : RDq[HW-1:0];
   end

   // misalignment and illegal width-code detection
   always_comb begin
      err = 1'b1;
      if (we_q) begin
         case (f3_q)
            3'b000:  err = 1'b0;
            3'b001:  err = a_q[0];
            3'b010:  err = (a_q[1:0] != 2'b00);
            default: err = 1'b1;
         endcase
      end else begin
         case (f3_q)
            3'b000,
            3'b100:  err = 1'b0;
            3'b001,
            3'b101:  err = a_q[0];
            3'b010:  err = (a_q[1:0] != 2'b00);
            default: err = 1'b1;
         endcase
      end
   end

   // load extension and store lane merge
   always_comb begin
      ld_data = '0;
      case (f3_q)
         3'b000:  ld_data = {{(DW-BW){bsel[BW-1]}}, bsel};
         3'b100:  ld_data = {{(DW-BW){1'b0}}, bsel};
         3'b001:  ld_data = {{(DW-HW){hsel[HW-1]}}, hsel};
         3'b101:  ld_data = {{(DW-HW){1'b0}}, hsel};
         3'b010:  ld_data = RDq;
         default: ld_data = '0;
      endcase
      wr_data = RDq;
      case (f3_q)
         3'b000: begin
            unique case (a_q[1:0])
               2'd0: wr_data[BW-1:0]      = rs2_q[BW-1:0];
               2'd1: wr_data[2*BW-1:BW]   = rs2_q[BW-1:0];
               2'd2: wr_data[3*BW-1:2*BW] = rs2_q[BW-1:0];
               2'd3: wr_data[4*BW-1:3*BW] = rs2_q[BW-1:0];
            endcase
         end
         3'b001: begin
            if (a_q[1]) wr_data[4*BW-1:2*BW] = rs2_q[HW-1:0];
            else        wr_data[HW-1:0]      = rs2_q[HW-1:0];
         end
         3'b010:  wr_data = rs2_q;
         default: wr_data = RDq;
      endcase
   end

   // memory write on the EXEC edge; contents survive reset
   always_ff @(posedge clk) begin
      if (rst_n && state == EXEC && we_q && !err)
         mem[a_q[AW-1:2]] <= wr_data;
   end

   // handshake and response outputs, all zero outside EXEC
   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.rsp_valid = (state == EXEC);
      bus.rsp_err   = (state == EXEC) && err;
      bus.rsp_data  = '0;
      if (state == EXEC && !err && !we_q)
         bus.rsp_data = ld_data;
   end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: driver queues expected
// responses, a negedge monitor pops and compares them.
module tb_data_mem_ctrl;
   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   fails;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb_q[$];

   data_mem_ctrl_if #(
      .DATA_WIDTH(32),
      .ADDRESS_WIDTH(9)
   ) bus ();

   data_mem_ctrl #(
      .DATA_WIDTH(32),
      .BYTE_WIDTH(8),
      .ADDRESS_WIDTH(9)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor: compare each response against the scoreboard head
   always @(negedge clk) begin : mon
      exp_t e;
      if (bus.rsp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rsp: got valid at cycle %0d expected none",
                     cyc);
         end else begin
            e = sb_q.pop_front();
            chk({e.name, "_data"}, bus.rsp_data, e.data);
            chk({e.name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
            chk({e.name, "_cycle"}, cyc, e.cyc);
         end
      end else begin
         chk("idle_rsp", {bus.rsp_err, bus.rsp_data[30:0]}, 32'd0);
      end
   end

   // present a request; caller is at a negedge. Ends one negedge later.
   task automatic issue(input logic we, input logic [2:0] f3,
                        input logic [8:0] a, input logic [31:0] d,
                        input logic [31:0] xd, input logic xe,
                        input string nm, input bit push,
                        output int acc);
      int n;
      exp_t e;
      n = 0;
      bus.req_we    = we;
      bus.funct3    = f3;
      bus.A         = a;
      bus.rs2       = d;
      bus.req_valid = 1'b1;
      while (bus.req_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (bus.req_ready !== 1'b1) begin
         checks++;
         fails++;
         $display("FAIL %s_accept: got ready=%b expected 1", nm, bus.req_ready);
         acc = -1;
      end else begin
         acc = cyc;
         if (push) begin
            e.data = xd;
            e.err  = xe;
            e.cyc  = cyc + 2;
            e.name = nm;
            sb_q.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.req_valid = 1'b0;
      while (sb_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int acc;
      int c0;
      int a1;
      int a2;
      int a3;
      cyc           = 0;
      checks        = 0;
      fails         = 0;
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.funct3    = 3'd0;
      bus.A         = 9'd0;
      bus.rs2       = 32'd0;
      #2;
      chk("reset_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("reset_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("reset_data", bus.rsp_data, 32'd0);
      chk("reset_err", {31'd0, bus.rsp_err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      c0 = cyc;
      issue(1, 3'b010, 9'h010, 32'hDEADBEEF, 0, 0, "sw_010", 1, acc);
      chk("first_accept_cycle", acc, c0);
      issue(0, 3'b010, 9'h010, 0, 32'hDEADBEEF, 0, "lw_010", 1, acc);
      issue(1, 3'b000, 9'h011, 32'h123456AA, 0, 0, "sb_011", 1, acc);
      issue(0, 3'b010, 9'h010, 0, 32'hDEADAAEF, 0, "lw_after_sb", 1, acc);
      issue(0, 3'b000, 9'h011, 0, 32'hFFFFFFAA, 0, "lb_011", 1, acc);
      issue(0, 3'b100, 9'h011, 0, 32'h000000AA, 0, "lbu_011", 1, acc);
      issue(1, 3'b010, 9'h010, 32'hDEADBEEF, 0, 0, "sw_010_again", 1, acc);
      issue(1, 3'b001, 9'h012, 32'hFFFF8234, 0, 0, "sh_012", 1, acc);
      issue(0, 3'b010, 9'h010, 0, 32'h8234BEEF, 0, "lw_after_sh", 1, acc);
      issue(0, 3'b001, 9'h012, 0, 32'hFFFF8234, 0, "lh_012", 1, acc);
      issue(0, 3'b101, 9'h012, 0, 32'h00008234, 0, "lhu_012", 1, acc);
      issue(0, 3'b001, 9'h010, 0, 32'hFFFFBEEF, 0, "lh_010", 1, acc);
      issue(0, 3'b101, 9'h010, 0, 32'h0000BEEF, 0, "lhu_010", 1, acc);
      issue(0, 3'b000, 9'h013, 0, 32'hFFFFFF82, 0, "lb_013", 1, acc);
      issue(0, 3'b100, 9'h012, 0, 32'h00000034, 0, "lbu_012", 1, acc);
      issue(1, 3'b000, 9'h014, 32'h0000007F, 0, 0, "sb_014", 1, acc);
      issue(0, 3'b000, 9'h014, 0, 32'h0000007F, 0, "lb_014_pos", 1, acc);
      issue(1, 3'b001, 9'h013, 32'h00001111, 0, 1, "sh_013_mis", 1, acc);
      issue(0, 3'b010, 9'h010, 0, 32'h8234BEEF, 0, "lw_after_bad_sh", 1, acc);
      issue(0, 3'b010, 9'h012, 0, 0, 1, "lw_012_mis", 1, acc);
      issue(0, 3'b001, 9'h011, 0, 0, 1, "lh_011_mis", 1, acc);
      issue(1, 3'b011, 9'h010, 32'h0BADF00D, 0, 1, "st_f3_011", 1, acc);
      issue(0, 3'b010, 9'h010, 0, 32'h8234BEEF, 0, "lw_after_bad_st", 1, acc);
      issue(0, 3'b011, 9'h010, 0, 0, 1, "ld_f3_011", 1, acc);
      issue(0, 3'b110, 9'h010, 0, 0, 1, "ld_f3_110", 1, acc);
      issue(1, 3'b010, 9'h020, 32'h01234567, 0, 0, "sw_020", 1, acc);
      issue(0, 3'b010, 9'h020, 0, 32'h01234567, 0, "lw_020", 1, acc);
      drain();
      @(negedge clk);
      issue(1, 3'b010, 9'h020, 32'h55AA55AA, 0, 0, "sw_020_abort", 0, acc);
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("abort_valid", {31'd0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      c0 = cyc;
      issue(0, 3'b010, 9'h020, 0, 32'h01234567, 0, "lw_020_post", 1, acc);
      chk("post_reset_accept_cycle", acc, c0);
      drain();
      @(negedge clk);
      issue(0, 3'b010, 9'h010, 0, 32'h8234BEEF, 0, "burst0", 1, a1);
      issue(0, 3'b100, 9'h011, 0, 32'h000000BE, 0, "burst1", 1, a2);
      issue(0, 3'b010, 9'h020, 0, 32'h01234567, 0, "burst2", 1, a3);
      chk("burst_accept1", a2 - a1, 3);
      chk("burst_accept2", a3 - a1, 6);
      drain();
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
